// File: rtl/alu_reservation_station.sv
// Reservation station feeding the integer ALU: holds dispatched ops until both operands arrive, issues one per cycle.
// Optional macro RS_PERF_CNT_EN adds rs_full_cycles_out, a saturating count of dispatch attempts stalled by a full buffer.
module alu_reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 6,
    parameter int XLEN    = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              disp_en_in,
    input  logic [XLEN-1:0]   disp_vj_in,
    input  logic [XLEN-1:0]   disp_vk_in,
    input  logic              disp_qj_busy_in,
    input  logic              disp_qk_busy_in,
    input  logic [ROB_W-1:0]  disp_qj_in,
    input  logic [ROB_W-1:0]  disp_qk_in,
    input  logic [XLEN-1:0]   disp_A_in,
    input  logic [ROB_W-1:0]  disp_dest_in,
    input  logic [XLEN-1:0]   disp_pc_in,
    input  logic [TYPE_W-1:0] disp_type_in,
    output logic              rs_full_out,
    input  logic              cdb_alu_en_in,
    input  logic [ROB_W-1:0]  cdb_alu_dest_in,
    input  logic [XLEN-1:0]   cdb_alu_value_in,
    input  logic              cdb_lsb_en_in,
    input  logic [ROB_W-1:0]  cdb_lsb_dest_in,
    input  logic [XLEN-1:0]   cdb_lsb_value_in,
    input  logic              rob_flush_in,
    output logic              rs_en_out,
    output logic [XLEN-1:0]   rs_vj_out,
    output logic [XLEN-1:0]   rs_vk_out,
    output logic [XLEN-1:0]   rs_A_out,
    output logic [ROB_W-1:0]  rs_dest_out,
    output logic [XLEN-1:0]   rs_pc_out,
    output logic [TYPE_W-1:0] rs_inst_type_out
`ifdef RS_PERF_CNT_EN
    ,
    output logic [31:0]       rs_full_cycles_out
`endif
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0]             busy;
    logic [RS_SIZE-1:0]             ready;
    logic [RS_SIZE-1:0][XLEN-1:0]   vj_all;
    logic [RS_SIZE-1:0][XLEN-1:0]   vk_all;
    logic [RS_SIZE-1:0][XLEN-1:0]   a_all;
    logic [RS_SIZE-1:0][XLEN-1:0]   pc_all;
    logic [RS_SIZE-1:0][ROB_W-1:0]  dest_all;
    logic [RS_SIZE-1:0][TYPE_W-1:0] type_all;

    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic              issue_valid;
    logic              disp_go;
    logic [XLEN-1:0]   disp_vj_eff;
    logic [XLEN-1:0]   disp_vk_eff;
    logic              disp_qj_busy_eff;
    logic              disp_qk_busy_eff;

    assign rs_full_out = &busy;
    assign disp_go     = disp_en_in && !rs_full_out;
    assign issue_valid = |ready;

    // Descending scans leave the lowest matching index in the result.
    always_comb begin
        free_idx  = '0;
        issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = IDX_W'(i);
            if (ready[i])
                issue_idx = IDX_W'(i);
        end
    end

    // Operands whose producer broadcasts in the dispatch cycle are captured directly.
    always_comb begin
        disp_vj_eff      = disp_vj_in;
        disp_qj_busy_eff = disp_qj_busy_in;
        disp_vk_eff      = disp_vk_in;
        disp_qk_busy_eff = disp_qk_busy_in;
        if (disp_qj_busy_in) begin
            if (cdb_lsb_en_in && cdb_lsb_dest_in == disp_qj_in) begin
                disp_vj_eff      = cdb_lsb_value_in;
                disp_qj_busy_eff = 1'b0;
            end else if (cdb_alu_en_in && cdb_alu_dest_in == disp_qj_in) begin
                disp_vj_eff      = cdb_alu_value_in;
                disp_qj_busy_eff = 1'b0;
            end
        end
        if (disp_qk_busy_in) begin
            if (cdb_lsb_en_in && cdb_lsb_dest_in == disp_qk_in) begin
                disp_vk_eff      = cdb_lsb_value_in;
                disp_qk_busy_eff = 1'b0;
            end else if (cdb_alu_en_in && cdb_alu_dest_in == disp_qk_in) begin
                disp_vk_eff      = cdb_alu_value_in;
                disp_qk_busy_eff = 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic              busy_reg;
        logic              qj_busy_reg;
        logic              qk_busy_reg;
        logic [ROB_W-1:0]  qj_reg;
        logic [ROB_W-1:0]  qk_reg;
        logic [XLEN-1:0]   vj_reg;
        logic [XLEN-1:0]   vk_reg;
        logic [XLEN-1:0]   a_reg;
        logic [XLEN-1:0]   pc_reg;
        logic [ROB_W-1:0]  dest_reg;
        logic [TYPE_W-1:0] type_reg;
        logic              disp_sel;
        logic              issue_sel;
        logic              alu_j_hit;
        logic              lsb_j_hit;
        logic              alu_k_hit;
        logic              lsb_k_hit;

        assign disp_sel  = disp_go && (free_idx == IDX_W'(gi));
        assign issue_sel = issue_valid && (issue_idx == IDX_W'(gi));
        assign alu_j_hit = cdb_alu_en_in && qj_busy_reg && (qj_reg == cdb_alu_dest_in);
        assign lsb_j_hit = cdb_lsb_en_in && qj_busy_reg && (qj_reg == cdb_lsb_dest_in);
        assign alu_k_hit = cdb_alu_en_in && qk_busy_reg && (qk_reg == cdb_alu_dest_in);
        assign lsb_k_hit = cdb_lsb_en_in && qk_busy_reg && (qk_reg == cdb_lsb_dest_in);

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                busy_reg    <= 1'b0;
                qj_busy_reg <= 1'b0;
                qk_busy_reg <= 1'b0;
                qj_reg      <= '0;
                qk_reg      <= '0;
                vj_reg      <= '0;
                vk_reg      <= '0;
                a_reg       <= '0;
                pc_reg      <= '0;
                dest_reg    <= '0;
                type_reg    <= '0;
            end else if (rob_flush_in) begin
                busy_reg <= 1'b0;
            end else if (rdy_in) begin
                if (disp_sel) begin
                    busy_reg    <= 1'b1;
                    vj_reg      <= disp_vj_eff;
                    vk_reg      <= disp_vk_eff;
                    qj_busy_reg <= disp_qj_busy_eff;
                    qk_busy_reg <= disp_qk_busy_eff;
                    qj_reg      <= disp_qj_in;
                    qk_reg      <= disp_qk_in;
                    a_reg       <= disp_A_in;
                    pc_reg      <= disp_pc_in;
                    dest_reg    <= disp_dest_in;
                    type_reg    <= disp_type_in;
                end else if (busy_reg) begin
                    if (issue_sel)
                        busy_reg <= 1'b0;
                    // LSB takes precedence if both buses name the same tag.
                    if (lsb_j_hit) begin
                        vj_reg      <= cdb_lsb_value_in;
                        qj_busy_reg <= 1'b0;
                    end else if (alu_j_hit) begin
                        vj_reg      <= cdb_alu_value_in;
                        qj_busy_reg <= 1'b0;
                    end
                    if (lsb_k_hit) begin
                        vk_reg      <= cdb_lsb_value_in;
                        qk_busy_reg <= 1'b0;
                    end else if (alu_k_hit) begin
                        vk_reg      <= cdb_alu_value_in;
                        qk_busy_reg <= 1'b0;
                    end
                end
            end
        end

        assign busy[gi]     = busy_reg;
        assign ready[gi]    = busy_reg && !qj_busy_reg && !qk_busy_reg;
        assign vj_all[gi]   = vj_reg;
        assign vk_all[gi]   = vk_reg;
        assign a_all[gi]    = a_reg;
        assign pc_all[gi]   = pc_reg;
        assign dest_all[gi] = dest_reg;
        assign type_all[gi] = type_reg;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rs_en_out        <= 1'b0;
            rs_vj_out        <= '0;
            rs_vk_out        <= '0;
            rs_A_out         <= '0;
            rs_dest_out      <= '0;
            rs_pc_out        <= '0;
            rs_inst_type_out <= '0;
        end else if (rob_flush_in || !rdy_in || !issue_valid) begin
            rs_en_out <= 1'b0;
        end else begin
            rs_en_out        <= 1'b1;
            rs_vj_out        <= vj_all[issue_idx];
            rs_vk_out        <= vk_all[issue_idx];
            rs_A_out         <= a_all[issue_idx];
            rs_dest_out      <= dest_all[issue_idx];
            rs_pc_out        <= pc_all[issue_idx];
            rs_inst_type_out <= type_all[issue_idx];
        end
    end

`ifdef RS_PERF_CNT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            rs_full_cycles_out <= '0;
        else if (rs_full_out && disp_en_in && rdy_in && rs_full_cycles_out != 32'hFFFF_FFFF)
            rs_full_cycles_out <= rs_full_cycles_out + 32'd1;
    end
`endif

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: issue latency, wakeup, bypass, full, flush, reset and stall.
module tb_alu_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        disp_en_in;
    logic [31:0] disp_vj_in, disp_vk_in, disp_A_in, disp_pc_in;
    logic        disp_qj_busy_in, disp_qk_busy_in;
    logic [3:0]  disp_qj_in, disp_qk_in, disp_dest_in;
    logic [5:0]  disp_type_in;
    logic        rs_full_out;
    logic        cdb_alu_en_in, cdb_lsb_en_in;
    logic [3:0]  cdb_alu_dest_in, cdb_lsb_dest_in;
    logic [31:0] cdb_alu_value_in, cdb_lsb_value_in;
    logic        rob_flush_in;
    logic        rs_en_out;
    logic [31:0] rs_vj_out, rs_vk_out, rs_A_out, rs_pc_out;
    logic [3:0]  rs_dest_out;
    logic [5:0]  rs_inst_type_out;
`ifdef RS_PERF_CNT_EN
    logic [31:0] rs_full_cycles_out;
`endif

    int compared   = 0;
    int mismatched = 0;

    alu_reservation_station dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .disp_en_in(disp_en_in), .disp_vj_in(disp_vj_in), .disp_vk_in(disp_vk_in),
        .disp_qj_busy_in(disp_qj_busy_in), .disp_qk_busy_in(disp_qk_busy_in),
        .disp_qj_in(disp_qj_in), .disp_qk_in(disp_qk_in), .disp_A_in(disp_A_in),
        .disp_dest_in(disp_dest_in), .disp_pc_in(disp_pc_in), .disp_type_in(disp_type_in),
        .rs_full_out(rs_full_out),
        .cdb_alu_en_in(cdb_alu_en_in), .cdb_alu_dest_in(cdb_alu_dest_in), .cdb_alu_value_in(cdb_alu_value_in),
        .cdb_lsb_en_in(cdb_lsb_en_in), .cdb_lsb_dest_in(cdb_lsb_dest_in), .cdb_lsb_value_in(cdb_lsb_value_in),
        .rob_flush_in(rob_flush_in),
        .rs_en_out(rs_en_out), .rs_vj_out(rs_vj_out), .rs_vk_out(rs_vk_out), .rs_A_out(rs_A_out),
        .rs_dest_out(rs_dest_out), .rs_pc_out(rs_pc_out), .rs_inst_type_out(rs_inst_type_out)
`ifdef RS_PERF_CNT_EN
        , .rs_full_cycles_out(rs_full_cycles_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic disp(input logic [31:0] vj, input logic [31:0] vk,
                        input logic qjb, input logic [3:0] qj,
                        input logic qkb, input logic [3:0] qk,
                        input logic [3:0] dest, input logic [31:0] pc, input logic [5:0] ty);
        disp_en_in      = 1'b1;
        disp_vj_in      = vj;
        disp_vk_in      = vk;
        disp_qj_busy_in = qjb;
        disp_qj_in      = qj;
        disp_qk_busy_in = qkb;
        disp_qk_in      = qk;
        disp_dest_in    = dest;
        disp_pc_in      = pc;
        disp_type_in    = ty;
        disp_A_in       = pc + 32'h11;
    endtask

    task automatic idle();
        disp_en_in    = 1'b0;
        cdb_alu_en_in = 1'b0;
        cdb_lsb_en_in = 1'b0;
        rob_flush_in  = 1'b0;
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1;
        disp_vj_in = '0; disp_vk_in = '0; disp_A_in = '0; disp_pc_in = '0;
        disp_qj_busy_in = 1'b0; disp_qk_busy_in = 1'b0;
        disp_qj_in = '0; disp_qk_in = '0; disp_dest_in = '0; disp_type_in = '0;
        cdb_alu_dest_in = '0; cdb_lsb_dest_in = '0; cdb_alu_value_in = '0; cdb_lsb_value_in = '0;
        idle();

        // reset state
        step(); step();
        chk("rst_en", 32'(rs_en_out), 32'd0);
        chk("rst_full", 32'(rs_full_out), 32'd0);
        chk("rst_vj", rs_vj_out, 32'd0);
        chk("rst_dest", 32'(rs_dest_out), 32'd0);
        @(negedge clk_in); rst_in = 1'b1;

        // ready ADD issues one cycle after dispatch
        disp(32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 32'h100, 6'd1);
        step(); idle();
        chk("add_lat0", 32'(rs_en_out), 32'd0);
        step();
        chk("add_en", 32'(rs_en_out), 32'd1);
        chk("add_vj", rs_vj_out, 32'd5);
        chk("add_vk", rs_vk_out, 32'd7);
        chk("add_dest", 32'(rs_dest_out), 32'd4);
        chk("add_pc", rs_pc_out, 32'h100);
        chk("add_A", rs_A_out, 32'h111);
        chk("add_type", 32'(rs_inst_type_out), 32'd1);
        step();
        chk("add_freed", 32'(rs_en_out), 32'd0);
        chk("add_hold_vj", rs_vj_out, 32'd5);

        // SUB waiting on tag 3, woken by ALU broadcast
        disp(32'd0, 32'd2, 1'b1, 4'd3, 1'b0, 4'd0, 4'd5, 32'h200, 6'd2);
        step(); idle();
        chk("sub_wait", 32'(rs_en_out), 32'd0);
        cdb_alu_en_in = 1'b1; cdb_alu_dest_in = 4'd3; cdb_alu_value_in = 32'h10;
        step(); idle();
        chk("sub_wake", 32'(rs_en_out), 32'd0);
        step();
        chk("sub_en", 32'(rs_en_out), 32'd1);
        chk("sub_vj", rs_vj_out, 32'h10);
        chk("sub_vk", rs_vk_out, 32'd2);
        chk("sub_dest", 32'(rs_dest_out), 32'd5);

        // same-cycle LSB bypass on qk
        disp(32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd2, 4'd6, 32'h300, 6'd3);
        cdb_lsb_en_in = 1'b1; cdb_lsb_dest_in = 4'd2; cdb_lsb_value_in = 32'hAB;
        step(); idle();
        chk("byp_lat0", 32'(rs_en_out), 32'd0);
        step();
        chk("byp_en", 32'(rs_en_out), 32'd1);
        chk("byp_vk", rs_vk_out, 32'hAB);
        chk("byp_dest", 32'(rs_dest_out), 32'd6);
        step();

        // fill all 16 entries waiting on tag 9
        for (int i = 0; i < 16; i++) begin
            disp(32'(i), 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, 4'(i), 32'h400, 6'd4);
            step();
        end
        idle();
        chk("fill_full", 32'(rs_full_out), 32'd1);
        chk("fill_noiss", 32'(rs_en_out), 32'd0);
        disp(32'hEE, 32'hEE, 1'b0, 4'd0, 1'b0, 4'd0, 4'hE, 32'h500, 6'd5);
        step(); idle();
        chk("over_full", 32'(rs_full_out), 32'd1);
        chk("over_noiss", 32'(rs_en_out), 32'd0);
`ifdef RS_PERF_CNT_EN
        chk("perf_cnt", rs_full_cycles_out, 32'd1);
`endif
        cdb_alu_en_in = 1'b1; cdb_alu_dest_in = 4'd9; cdb_alu_value_in = 32'h99;
        step(); idle();
        chk("fill_wake", 32'(rs_en_out), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("drain_en", 32'(rs_en_out), 32'd1);
            chk("drain_dest", 32'(rs_dest_out), 32'(i));
            chk("drain_vj", rs_vj_out, 32'h99);
        end
        step();
        chk("drain_done", 32'(rs_en_out), 32'd0);
        chk("drain_full", 32'(rs_full_out), 32'd0);

        // flush with simultaneous dispatch
        for (int i = 0; i < 4; i++) begin
            disp(32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'(i), 32'h600, 6'd6);
            step();
        end
        disp(32'h55, 32'h55, 1'b0, 4'd0, 1'b0, 4'd0, 4'hA, 32'h700, 6'd7);
        rob_flush_in = 1'b1;
        step(); idle();
        chk("flush_en", 32'(rs_en_out), 32'd0);
        chk("flush_full", 32'(rs_full_out), 32'd0);
        cdb_alu_en_in = 1'b1; cdb_alu_dest_in = 4'd7; cdb_alu_value_in = 32'h77;
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_quiet", 32'(rs_en_out), 32'd0);
        end

        // asynchronous reset during issue
        disp(32'h77, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h800, 6'd8);
        step(); idle();
        step();
        chk("pre_rst_en", 32'(rs_en_out), 32'd1);
        chk("pre_rst_vj", rs_vj_out, 32'h77);
        #2 rst_in = 1'b0;
        #1;
        chk("async_en", 32'(rs_en_out), 32'd0);
        chk("async_vj", rs_vj_out, 32'd0);
        @(negedge clk_in); rst_in = 1'b1;

        // stall with a ready entry
        disp(32'h33, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 32'h900, 6'd9);
        step(); idle();
        rdy_in = 1'b0;
        step();
        chk("stall_en0", 32'(rs_en_out), 32'd0);
        step();
        chk("stall_en1", 32'(rs_en_out), 32'd0);
        rdy_in = 1'b1;
        step();
        chk("resume_en", 32'(rs_en_out), 32'd1);
        chk("resume_vj", rs_vj_out, 32'h33);
        chk("resume_dest", 32'(rs_dest_out), 32'd6);
        rdy_in = 1'b0;
        step();
        chk("stall_clr", 32'(rs_en_out), 32'd0);
        chk("stall_hold", rs_vj_out, 32'h33);
        rdy_in = 1'b1;
        step();
        chk("empty_after", 32'(rs_en_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Out-of-order issue buffer sitting directly upstream of the integer ALU.
- Accepts decoded instructions from dispatch and holds them until both operands are valid.
- Snoops the ALU and LSB common-data-bus broadcasts to capture pending operands.
- Issues one ready instruction per cycle on registered outputs that drive the ALU's rs_* inputs.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32).
- ROB_W, 4, ROB tag width; ROB depth is 2**ROB_W.
- TYPE_W, 6, instruction-type code width.
- XLEN, 32, data/address width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; when 0, the block stalls.
- disp_en_in  in  1  dispatch valid.
- disp_vj_in, disp_vk_in  in  XLEN  operand values.
- disp_qj_busy_in, disp_qk_busy_in  in  1  operand pending, value not yet known.
- disp_qj_in, disp_qk_in  in  ROB_W  producing ROB tag for each operand.
- disp_A_in  in  XLEN  immediate.
- disp_dest_in  in  ROB_W  destination ROB tag.
- disp_pc_in  in  XLEN  instruction pc.
- disp_type_in  in  TYPE_W  instruction type.
- rs_full_out  out  1  no free entry (combinational).
- cdb_alu_en_in  in  1  ALU broadcast valid.
- cdb_alu_dest_in  in  ROB_W  ALU broadcast tag.
- cdb_alu_value_in  in  XLEN  ALU broadcast value.
- cdb_lsb_en_in  in  1  LSB broadcast valid.
- cdb_lsb_dest_in  in  ROB_W  LSB broadcast tag.
- cdb_lsb_value_in  in  XLEN  LSB broadcast value.
- rob_flush_in  in  1  mispredict flush.
- rs_en_out  out  1  issue valid to ALU (registered).
- rs_vj_out, rs_vk_out, rs_A_out  out  XLEN  issued operands and immediate.
- rs_dest_out  out  ROB_W  issued destination tag.
- rs_pc_out  out  XLEN  issued pc.
- rs_inst_type_out  out  TYPE_W  issued instruction type.

Behaviour:
- Entry state: busy, vj, vk, qj_busy, qk_busy, qj, qk, A, dest, pc, type.
- Reset (rst_in=0, asynchronous): all busy=0, rs_en_out=0, every other output 0.
- rdy_in=0: no entry changes; rs_en_out cleared to 0 at each edge; the other outputs hold their values.
- Flush (rob_flush_in=1 at an edge):
  - All busy cleared and rs_en_out=0 next cycle.
  - Dispatch and issue in the same cycle are discarded.
  - Flush outranks everything except reset.
- Dispatch (disp_en_in=1, rs_full_out=0): writes the lowest-index free entry.
  - Same-cycle bypass: if a pending operand tag matches a valid CDB broadcast in the dispatch cycle, store the broadcast value with busy=0.
  - Dispatch while rs_full_out=1 is ignored; the upstream stage must hold.
- Wakeup: every busy entry compares qj/qk against both CDB tags each cycle. On a match, capture the value and clear the q-busy flag. If both CDBs match one operand, the LSB value wins; the ROB guarantees this cannot happen legally.
- Ready = busy & !qj_busy & !qk_busy, evaluated on registered state. An operand woken this cycle is eligible next cycle.
- Issue: lowest-index ready entry. At the edge, its fields load into the rs_*_out registers, rs_en_out=1, and the entry's busy clears. With no ready entry, rs_en_out=0 and the data outputs hold.
- Latency:
  - Dispatch of a fully-ready instruction at edge N: issue register loaded at N+1, so rs_en_out is high during cycle N+1..N+2.
  - ALU result returns on the CDB in that same cycle.
- rs_full_out = all entries busy. A slot freed by issue becomes usable for dispatch only on the following cycle; simultaneous issue and dispatch into a full buffer is not allowed.
- Dispatch and issue in the same cycle target distinct entries.

Optional Feature:
- Macro: RS_PERF_CNT_EN.
- Defined:
  - Adds output rs_full_cycles_out [31:0], counting cycles with rs_full_out=1 && disp_en_in=1 && rdy_in=1.
  - The counter saturates at 0xFFFFFFFF.
  - Cleared only by reset, not by flush.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Dispatch ADD, vj=5, vk=7, both ready -> rs_en_out=1 one cycle later with vj=5, vk=7, dest echoed; the entry is freed.
- Dispatch SUB with qj_busy, qj=3 -> no issue; drive cdb_alu_en=1, dest=3, value=0x10 -> issue the following cycle with vj=0x10.
- Dispatch with qk=2 while cdb_lsb_en=1, dest=2, value=0xAB in the same cycle -> stored ready; issues next cycle with vk=0xAB.
- Fill 16 entries all waiting on tag 9 -> rs_full_out=1; a 17th dispatch is ignored. Broadcast tag 9 -> entries issue in index order 0..15, one per cycle.
- 4 pending entries; assert rob_flush_in with a simultaneous dispatch -> next cycle rs_en_out=0, rs_full_out=0, no entry issues afterwards.
- Reset low mid-issue -> rs_en_out drops to 0 immediately; rdy_in=0 with a ready entry -> no issue until rdy_in returns to 1.
